// File: rtl/e203_extend_csr_bank.sv
// NICE-side custom CSR bank: free-running cycle counter, write counter and RW scratch
// registers behind a request/response handshake with a single buffered response.
module e203_extend_csr_bank #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       NUM_REGS  = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'hBC0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nice_csr_valid,
    output logic              nice_csr_ready,
    input  logic [ADDR_W-1:0] nice_csr_addr,
    input  logic              nice_csr_wr,
    input  logic [DATA_W-1:0] nice_csr_wdata,
    output logic              nice_csr_rsp_valid,
    input  logic              nice_csr_rsp_ready,
    output logic [DATA_W-1:0] nice_csr_rdata,
    output logic              nice_csr_rsp_err
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    typedef enum logic {IDLE, RESP} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  idx;
    logic              hit;
    logic              is_ro;
    logic              accept;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_val;

    // Offset compare avoids overflow of BASE_ADDR+NUM_REGS near the top of the address space.
    always_comb begin
        offset = nice_csr_addr - BASE_ADDR;
        hit    = (nice_csr_addr >= BASE_ADDR) && (offset < ADDR_W'(NUM_REGS));
        idx    = offset[IDX_W-1:0];
        is_ro  = (idx < IDX_W'(2));
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (hit && idx == IDX_W'(i)) begin
                rd_val = regs[i];
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        nice_csr_ready     = 1'b0;
        nice_csr_rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                nice_csr_ready = 1'b1;
                if (nice_csr_valid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                nice_csr_rsp_valid = 1'b1;
                if (nice_csr_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        accept = nice_csr_valid && nice_csr_ready;
        wr_ok  = accept && hit && nice_csr_wr && !is_ro;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            nice_csr_rdata   <= '0;
            nice_csr_rsp_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            regs[0] <= regs[0] + DATA_W'(1);
            if (wr_ok) begin
                regs[1] <= regs[1] + DATA_W'(1);
            end
            for (int unsigned i = 2; i < NUM_REGS; i++) begin
                if (wr_ok && idx == IDX_W'(i)) begin
                    regs[i] <= nice_csr_wdata;
                end
            end
            if (accept) begin
                nice_csr_rdata   <= rd_val;
                nice_csr_rsp_err <= !hit || (nice_csr_wr && is_ro);
            end
        end
    end

endmodule

// File: tb/tb_e203_extend_csr_bank.sv
// Directed bench for e203_extend_csr_bank: a 32-bit bank for the main checks and an 8-bit
// bank to reach the write-counter wrap in a reasonable number of writes.
module tb_e203_extend_csr_bank;

    localparam logic [31:0] B = 32'hBC0;

    logic        clk = 1'b0;
    logic        rst;
    logic        v32, v8;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic        rsp_ready;
    logic        rdy32, rdy8, rv32, rv8, err32, err8;
    logic [31:0] rd32;
    logic [7:0]  rd8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    e203_extend_csr_bank #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(8), .BASE_ADDR(32'hBC0)) u_dut (
        .clk(clk), .rst(rst), .nice_csr_valid(v32), .nice_csr_ready(rdy32),
        .nice_csr_addr(addr), .nice_csr_wr(wr), .nice_csr_wdata(wdata),
        .nice_csr_rsp_valid(rv32), .nice_csr_rsp_ready(rsp_ready),
        .nice_csr_rdata(rd32), .nice_csr_rsp_err(err32)
    );

    e203_extend_csr_bank #(.ADDR_W(32), .DATA_W(8), .NUM_REGS(8), .BASE_ADDR(32'hBC0)) u_dut8 (
        .clk(clk), .rst(rst), .nice_csr_valid(v8), .nice_csr_ready(rdy8),
        .nice_csr_addr(addr), .nice_csr_wr(wr), .nice_csr_wdata(wdata[7:0]),
        .nice_csr_rsp_valid(rv8), .nice_csr_rsp_ready(rsp_ready),
        .nice_csr_rdata(rd8), .nice_csr_rsp_err(err8)
    );

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        bit          chk_d;
        logic [31:0] exp_d;
        bit          exp_e;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept happens at the first edge after valid is raised; response is sampled #1 later.
    task automatic txn(input bit s8, input logic [31:0] a, input bit w, input logic [31:0] d,
                       input bit hold, output logic [31:0] rd, output bit er);
        int unsigned n = 0;
        while (!(s8 ? rdy8 : rdy32) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", 32'(n < 50), 32'd1);
        addr = a; wr = w; wdata = d; rsp_ready = !hold;
        if (s8) v8 = 1'b1; else v32 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0; v32 = 1'b0;
        chk("rsp_latency", 32'(s8 ? rv8 : rv32), 32'd1);
        rd = s8 ? {24'b0, rd8} : rd32;
        er = s8 ? err8 : err32;
        if (!hold) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, c1, c2;
        bit er;

        vecs.push_back('{B+2,   0, 32'h0,        1, 32'h0,        0});
        vecs.push_back('{B+3,   1, 32'hDEADBEEF, 1, 32'h0,        0});
        vecs.push_back('{B+3,   0, 32'h0,        1, 32'hDEADBEEF, 0});
        vecs.push_back('{B+1,   0, 32'h0,        1, 32'h1,        0});
        vecs.push_back('{B+8,   0, 32'h0,        1, 32'h0,        1});
        vecs.push_back('{B+0,   1, 32'h5,        0, 32'h0,        1});
        vecs.push_back('{B+1,   0, 32'h0,        1, 32'h1,        0});
        vecs.push_back('{B-1,   0, 32'h0,        1, 32'h0,        1});
        vecs.push_back('{B+2,   1, 32'h12345678, 1, 32'h0,        0});
        vecs.push_back('{B+2,   1, 32'hCAFEF00D, 1, 32'h12345678, 0});
        vecs.push_back('{B+2,   0, 32'h0,        1, 32'hCAFEF00D, 0});
        vecs.push_back('{B+1,   0, 32'h0,        1, 32'h3,        0});
        vecs.push_back('{B+100, 1, 32'h9,        1, 32'h0,        1});
        vecs.push_back('{B+1,   1, 32'h7,        1, 32'h3,        1});
        vecs.push_back('{B+1,   0, 32'h0,        1, 32'h3,        0});
        vecs.push_back('{B+0,   0, 32'h0,        0, 32'h0,        0});
        vecs.push_back('{B+7,   1, 32'hA5,       1, 32'h0,        0});
        vecs.push_back('{B+7,   0, 32'h0,        1, 32'hA5,       0});
        vecs.push_back('{B+1,   0, 32'h0,        1, 32'h4,        0});

        rst = 1'b1; v32 = 1'b0; v8 = 1'b0; addr = '0; wr = 1'b0; wdata = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", 32'(rdy32), 32'd1);
        chk("rst_rsp_valid", 32'(rv32), 32'd0);
        chk("rst_rdata", rd32, 32'd0);
        chk("rst_err", 32'(err32), 32'd0);

        foreach (vecs[i]) begin
            txn(0, vecs[i].addr, vecs[i].wr, vecs[i].wdata, 0, rd, er);
            if (vecs[i].chk_d) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_d);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_e));
        end

        // Backpressure: a second request raised while the response is stalled must be ignored.
        txn(0, B+4, 1, 32'h11, 1, rd, er);
        addr = B+5; wr = 1'b1; wdata = 32'h22; v32 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", 32'(rv32), 32'd1);
            chk("bp_ready", 32'(rdy32), 32'd0);
            chk("bp_rdata", rd32, 32'h0);
        end
        v32 = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(rv32), 32'd0);
        chk("bp_release_ready", 32'(rdy32), 32'd1);
        txn(0, B+5, 0, 0, 0, rd, er); chk("bp_idx5_untouched", rd, 32'h0);
        txn(0, B+4, 0, 0, 0, rd, er); chk("bp_idx4", rd, 32'h11);
        txn(0, B+1, 0, 0, 0, rd, er); chk("bp_wrcnt", rd, 32'h5);

        // Accepts are 2 cycles apart back to back, plus 7 idle cycles in between.
        txn(0, B+0, 0, 0, 0, c1, er);
        repeat (7) @(posedge clk);
        #1;
        txn(0, B+0, 0, 0, 0, c2, er);
        chk("cycle_delta", c2 - c1, 32'd9);
        chk("cycle_err", 32'(er), 32'd0);

        txn(0, B+6, 1, 32'h77, 1, rd, er);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_rsp_valid", 32'(rv32), 32'd0);
        chk("midrst_ready", 32'(rdy32), 32'd1);
        chk("midrst_rdata", rd32, 32'd0);
        rst = 1'b0; rsp_ready = 1'b1;
        txn(0, B+6, 0, 0, 0, rd, er); chk("midrst_idx6", rd, 32'h0);
        txn(0, B+3, 0, 0, 0, rd, er); chk("midrst_idx3", rd, 32'h0);
        txn(0, B+1, 0, 0, 0, rd, er); chk("midrst_wrcnt", rd, 32'h0);

        for (int k = 0; k < 255; k++) begin
            txn(1, B+2, 1, 32'(k), 0, rd, er);
        end
        txn(1, B+2, 0, 0, 0, rd, er); chk("w8_idx2", rd, 32'hFE);
        txn(1, B+1, 0, 0, 0, rd, er); chk("w8_wrcnt_max", rd, 32'hFF);
        txn(1, B+3, 1, 32'h3C, 0, rd, er); chk("w8_wrap_write_err", 32'(er), 32'd0);
        txn(1, B+1, 0, 0, 0, rd, er); chk("w8_wrcnt_wrap", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
